// File: rtl/mux_4to1.sv
// 4:1 multiplexer with a combinational output and a registered copy.
// y_vld flags a Y_q value that was loaded on the most recent edge.
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             S1,
  input  logic             S2,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             y_vld
);

  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic             r_vld;

  assign w_sel = {S1, S2};

  // Fully decoded 4-way select; default keeps the block latch-free
  always_comb begin
    w_y = '0;
    case (w_sel)
      2'b00:   w_y = i0;
      2'b01:   w_y = i1;
      2'b10:   w_y = i2;
      2'b11:   w_y = i3;
      default: w_y = 'x;
    endcase
  end

  // Output register: reset wins, then load on en, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q <= '0;
      r_vld <= 1'b0;
    end else if (en) begin
      r_y_q <= w_y;
      r_vld <= 1'b1;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign Y     = w_y;
  assign Y_q   = r_y_q;
  assign y_vld = r_vld;

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1 at WIDTH 1, 8 and 32.
// Random and directed stimulus against an array-indexed reference model.
module tb_mux_4to1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // WIDTH=1 instance
  logic a_rst, a_en, a_s1, a_s2;
  logic a_i0, a_i1, a_i2, a_i3;
  logic a_y, a_yq, a_vld;

  mux_4to1 #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(a_rst), .en(a_en),
    .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3),
    .S1(a_s1), .S2(a_s2),
    .Y(a_y), .Y_q(a_yq), .y_vld(a_vld)
  );

  // WIDTH=8 instance
  logic       b_rst, b_en, b_s1, b_s2;
  logic [7:0] b_i0, b_i1, b_i2, b_i3;
  logic [7:0] b_y, b_yq;
  logic       b_vld;

  mux_4to1 #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(b_rst), .en(b_en),
    .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3),
    .S1(b_s1), .S2(b_s2),
    .Y(b_y), .Y_q(b_yq), .y_vld(b_vld)
  );

  // WIDTH=32 instance
  logic        c_rst, c_en, c_s1, c_s2;
  logic [31:0] c_i0, c_i1, c_i2, c_i3;
  logic [31:0] c_y, c_yq;
  logic        c_vld;

  mux_4to1 #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(c_rst), .en(c_en),
    .i0(c_i0), .i1(c_i1), .i2(c_i2), .i3(c_i3),
    .S1(c_s1), .S2(c_s2),
    .Y(c_y), .Y_q(c_yq), .y_vld(c_vld)
  );

  // Reference state for the registered outputs
  logic [7:0]  m8_q;
  logic        m8_v;
  logic [31:0] m32_q;
  logic        m32_v;

  // One clock of the 8-bit instance: drive, check Y, step model, check Y_q
  task automatic cyc8(input logic r, input logic e,
                      input logic [1:0] sel,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    @(negedge clk);
    b_rst = r; b_en = e; {b_s1, b_s2} = sel;
    b_i0 = d0; b_i1 = d1; b_i2 = d2; b_i3 = d3;
    #1;
    chk("w8_Y", 64'(b_y), 64'(d[sel]));
    if (r) begin
      m8_q = '0; m8_v = 1'b0;
    end else if (e) begin
      m8_q = d[sel]; m8_v = 1'b1;
    end else begin
      m8_v = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("w8_Yq", 64'(b_yq), 64'(m8_q));
    chk("w8_vld", 64'(b_vld), 64'(m8_v));
  endtask

  task automatic cyc32(input logic r, input logic e,
                       input logic [1:0] sel,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    @(negedge clk);
    c_rst = r; c_en = e; {c_s1, c_s2} = sel;
    c_i0 = d0; c_i1 = d1; c_i2 = d2; c_i3 = d3;
    #1;
    chk("w32_Y", 64'(c_y), 64'(d[sel]));
    if (r) begin
      m32_q = '0; m32_v = 1'b0;
    end else if (e) begin
      m32_q = d[sel]; m32_v = 1'b1;
    end else begin
      m32_v = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("w32_Yq", 64'(c_yq), 64'(m32_q));
    chk("w32_vld", 64'(c_vld), 64'(m32_v));
  endtask

  initial begin
    logic [5:0] v;
    logic [3:0] data;
    logic [1:0] s;

    a_rst = 1'b1; a_en = 1'b0;
    {a_s1, a_s2, a_i3, a_i2, a_i1, a_i0} = '0;
    b_rst = 1'b1; b_en = 1'b0; b_s1 = 1'b0; b_s2 = 1'b0;
    b_i0 = '0; b_i1 = '0; b_i2 = '0; b_i3 = '0;
    c_rst = 1'b1; c_en = 1'b0; c_s1 = 1'b0; c_s2 = 1'b0;
    c_i0 = '0; c_i1 = '0; c_i2 = '0; c_i3 = '0;
    m8_q = '0; m8_v = 1'b0; m32_q = '0; m32_v = 1'b0;

    // Exhaustive WIDTH=1 sweep under reset
    for (int k = 0; k < 64; k++) begin
      v = 6'(k);
      {a_s1, a_s2, a_i3, a_i2, a_i1, a_i0} = v;
      #10;
      data = v[3:0];
      s    = v[5:4];
      chk("w1_Y", 64'(a_y), 64'(data[s]));
    end
    chk("w1_Yq_rst", 64'(a_yq), 64'd0);
    chk("w1_vld_rst", 64'(a_vld), 64'd0);

    // Reset state, then preload A5 and reset with en high
    cyc8(1, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc8(0, 1, 2'b00, 8'hA5, 8'h00, 8'h00, 8'h00);
    chk("w8_preload", 64'(b_yq), 64'hA5);
    cyc8(1, 1, 2'b10, 8'h11, 8'h22, 8'h3C, 8'h44);
    chk("w8_rst_clr", 64'(b_yq), 64'h00);

    // Stepped loads, then hold
    for (int k = 0; k < 4; k++)
      cyc8(0, 1, 2'(k), 8'h11, 8'h22, 8'h33, 8'h44);
    chk("w8_last_load", 64'(b_yq), 64'h44);
    cyc8(0, 0, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44);
    chk("w8_hold", 64'(b_yq), 64'h44);

    // Reset pulse inside a running load stream
    cyc8(0, 1, 2'b01, 8'h11, 8'h22, 8'h33, 8'h44);
    cyc8(1, 1, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);
    cyc8(0, 1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44);
    chk("w8_resume", 64'(b_yq), 64'h44);

    // Random traffic on the 8-bit instance
    for (int k = 0; k < 300; k++)
      cyc8(($urandom_range(15) == 0), ($urandom_range(3) != 0),
           2'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom));

    // Wide data
    cyc32(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    cyc32(0, 1, 2'b11, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF);
    chk("w32_wide", 64'(c_yq), 64'hDEADBEEF);
    for (int k = 0; k < 100; k++)
      cyc32(($urandom_range(15) == 0), ($urandom_range(3) != 0),
            2'($urandom), $urandom, $urandom, $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
